uart_tx_sched: RTL

Parametrised UART transmit scheduler sitting between the TX word FIFO and the UART byte transmitter.
- Pops one FIFO word, splits it into a programmable number of bytes, LSB-first or MSB-first.
- Hands each byte to the transmitter over a req/end handshake, with programmable pre-send and inter-byte gaps.
- Also supplies the registered baud divisor, half divisor and parity mode to the TX/RX datapath.

---
 rtl/uart_tx_sched.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - UART TX scheduler: FIFO word to byte stream with gaps, baud and parity setup
module uart_tx_sched #(
    parameter int unsigned BYTES_PER_WORD = 4,
    parameter int unsigned STARTUP_CYCLES = 65536,
    parameter int unsigned PRE_GAP        = 31,
    parameter int unsigned BYTE_GAP       = 21
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  logic                        uart_en_i,
    input  logic                        uart_msbf_i,
    input  logic [3:0]                  uart_nbytes_i,
    input  logic [3:0]                  uart_brr_i,
    input  logic                        uart_pce_i,
    input  logic                        uart_ps_i,
    input  logic                        txfifo_empty_i,
    output logic                        txfifo_rden_o,
    input  logic [8*BYTES_PER_WORD-1:0] txfifo_data_i,
    output logic                        tx_req_o,
    output logic [7:0]                  tx_data_o,
    input  logic                        tx_end_i,
    output logic                        word_done_o,
    output logic                        busy_o,
    output logic [31:0]                 baud_cnt_max_o,
    output logic [31:0]                 baud_cnt_half_o,
    output logic [1:0]                  parity_mode_o
);
    localparam int unsigned W            = 8 * BYTES_PER_WORD;
    localparam logic [31:0] STARTUP_LAST = STARTUP_CYCLES - 1;
    localparam logic [31:0] PRE_LAST     = PRE_GAP - 1;
    localparam logic [31:0] GAP_LAST     = BYTE_GAP - 1;

    typedef enum logic [2:0] {
        ST_STARTUP, ST_IDLE, ST_RDREQ, ST_LATCH, ST_PREGAP, ST_SEND, ST_GAP
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  rst_sync;
    logic        rst_n;
    logic [31:0] cnt;
    logic [W-1:0] word_q, src_word, shifted;
    logic [3:0]  nbytes_q, nbytes_eff, idx, idx_load, sel;
    logic        msbf_q, src_msbf, load_byte, last_byte;
    logic [7:0]  tx_data_q;
    logic        tx_req_q, word_done_q;
    logic [31:0] baud_val;
    logic        baud_hit;

    // Assert asynchronously, release only after two clean clock edges.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign nbytes_eff = (uart_nbytes_i == 4'd0 || uart_nbytes_i > 4'(BYTES_PER_WORD))
                        ? 4'(BYTES_PER_WORD) : uart_nbytes_i;
    assign last_byte  = (idx == nbytes_q - 4'd1);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) state <= ST_STARTUP;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_STARTUP: if (cnt == STARTUP_LAST) state_nxt = ST_IDLE;
            ST_IDLE:    if (uart_en_i && !txfifo_empty_i) state_nxt = ST_RDREQ;
            ST_RDREQ:   state_nxt = ST_LATCH;
            ST_LATCH:   state_nxt = (PRE_GAP == 0) ? ST_SEND : ST_PREGAP;
            ST_PREGAP:  if (cnt == PRE_LAST) state_nxt = ST_SEND;
            ST_SEND: begin
                if (tx_end_i) begin
                    if (last_byte)          state_nxt = ST_IDLE;
                    else if (BYTE_GAP == 0) state_nxt = ST_SEND;
                    else                    state_nxt = ST_GAP;
                end
            end
            ST_GAP:     if (cnt == GAP_LAST) state_nxt = ST_SEND;
            default:    state_nxt = ST_STARTUP;
        endcase
    end

    // Byte selection looks ahead to the index/word that will be current in SEND.
    always_comb begin
        src_word  = (state == ST_LATCH) ? txfifo_data_i : word_q;
        src_msbf  = (state == ST_LATCH) ? uart_msbf_i   : msbf_q;
        idx_load  = (state == ST_LATCH) ? 4'd0 : ((state == ST_SEND) ? idx + 4'd1 : idx);
        sel       = src_msbf ? 4'(BYTES_PER_WORD - 1) - idx_load : idx_load;
        shifted   = src_word >> {sel, 3'b000};
        load_byte = (state_nxt == ST_SEND) && ((state != ST_SEND) || tx_end_i);
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            word_q      <= '0;
            nbytes_q    <= '0;
            msbf_q      <= 1'b0;
            idx         <= '0;
            tx_data_q   <= '0;
            tx_req_q    <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            cnt <= (state_nxt != state) ? 32'd0 : cnt + 32'd1;
            if (state == ST_LATCH) begin
                word_q   <= txfifo_data_i;
                nbytes_q <= nbytes_eff;
                msbf_q   <= uart_msbf_i;
                idx      <= '0;
            end else if (state == ST_SEND && tx_end_i && !last_byte) begin
                idx <= idx + 4'd1;
            end
            if (load_byte) tx_data_q <= shifted[7:0];
            tx_req_q    <= (state_nxt == ST_SEND);
            word_done_q <= (state == ST_SEND) && tx_end_i && last_byte;
        end
    end

    always_comb begin
        baud_hit = 1'b1;
        baud_val = 32'd0;
        case (uart_brr_i)
            4'd0:  baud_val = 32'd13020;
            4'd1:  baud_val = 32'd6510;
            4'd2:  baud_val = 32'd3255;
            4'd3:  baud_val = 32'd2170;
            4'd4:  baud_val = 32'd1085;
            4'd5:  baud_val = 32'd125;
            4'd6:  baud_val = 32'd62;
            4'd7:  baud_val = 32'd41;
            4'd8:  baud_val = 32'd31;
            4'd9:  baud_val = 32'd25;
            4'd10: baud_val = 32'd135;
            4'd11: baud_val = 32'd542;
            default: baud_hit = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            baud_cnt_max_o  <= '0;
            baud_cnt_half_o <= '0;
            parity_mode_o   <= 2'b00;
        end else begin
            if (baud_hit) begin
                baud_cnt_max_o  <= baud_val;
                baud_cnt_half_o <= baud_val >> 1;
            end
            parity_mode_o <= !uart_pce_i ? 2'b00 : (uart_ps_i ? 2'b01 : 2'b10);
        end
    end

    assign txfifo_rden_o = (state == ST_RDREQ);
    assign busy_o        = (state != ST_STARTUP) && (state != ST_IDLE);
    assign tx_req_o      = tx_req_q;
    assign tx_data_o     = tx_data_q;
    assign word_done_o   = word_done_q;
endmodule
